// File: rtl/slave_in.sv
// slave_in: serial bus slave receiver (select, header and data deserialiser).
// Define ADDR_RANGE_CHECK_EN to add addr_err and reject upper-half addresses.
module slave_in #(
    parameter int SLAVE_LEN = 2,
    parameter int SLAVE_ID  = 0,
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12,
    parameter int TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_slave_select,
    input  logic                rx_address,
    input  logic                rx_burst_number,
    input  logic                rx_data,
    input  logic                master_valid,
    input  logic                write_en,
    input  logic                read_en,
    input  logic                rd_ack,
    output logic                slave_ready,
    output logic                selected,
    output logic                mem_wr_en,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic                rd_req,
    output logic [ADDR_LEN-1:0] rd_addr,
    output logic                rx_done,
`ifdef ADDR_RANGE_CHECK_EN
    output logic                addr_err,
`endif
    output logic                ovf_err
);

    localparam int HDR_MAX = (ADDR_LEN > BURST_LEN + 1) ? ADDR_LEN : BURST_LEN + 1;
    localparam int HDR_CYC = HDR_MAX + 1;
    localparam int CW  = $clog2(HDR_CYC + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int SW  = $clog2(SLAVE_LEN + 1);
    localparam int DW  = $clog2(DATA_LEN + 1);
    localparam int BW1 = BURST_LEN + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEL   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_XFER  = 3'd3;
    localparam logic [2:0] S_RDREQ = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CW-1:0] C_AEND = CW'(ADDR_LEN);
    localparam logic [CW-1:0] C_BEND = CW'(BURST_LEN + 1);
    localparam logic [CW-1:0] C_HDR  = CW'(HDR_CYC);
    localparam logic [CW-1:0] C_TWO  = CW'(2);

    logic [2:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [TW-1:0]        r_tmo;
    logic [SLAVE_LEN-1:0] r_sel_sr;
    logic [SW-1:0]        r_sel_cnt;
    logic                 r_is_wr;
    logic [ADDR_LEN-1:0]  r_addr;
    logic [BURST_LEN-1:0] r_burst;
    logic [DATA_LEN-2:0]  r_dsr;
    logic [DW-1:0]        r_dcnt;
    logic [DATA_LEN-1:0]  r_hold;
    logic                 r_full;
    logic [BURST_LEN-1:0] r_widx;

    logic                 w_req_one;
    logic                 w_abort;
    logic [SLAVE_LEN-1:0] w_id;
    logic                 w_hdr_done;
    logic                 w_commit;
    logic                 w_word_done;
    logic                 w_load;
    logic [DATA_LEN-1:0]  w_word;
    logic [ADDR_LEN-1:0]  w_tgt;
    logic [BURST_LEN-1:0] w_expect;
    logic                 w_last;
    logic                 w_bad;

    assign w_req_one   = write_en ^ read_en;
    assign w_abort     = !write_en && !read_en;
    assign w_id        = r_sel_sr | (SLAVE_LEN'(rx_slave_select) << r_sel_cnt);
    assign w_hdr_done  = (r_cnt == C_HDR);
    assign w_commit    = (r_state == S_XFER) && r_is_wr && w_hdr_done && r_full;
    assign w_word      = {rx_data, r_dsr};
    assign w_word_done = master_valid && (r_dcnt == DW'(DATA_LEN - 1));
    // A word landing on the same edge the holder drains is accepted.
    assign w_load      = w_word_done && (!r_full || w_commit);
    assign w_tgt       = r_addr + ADDR_LEN'(r_widx);
    assign w_expect    = (r_burst == '0) ? BURST_LEN'(1) : r_burst;
    assign w_last      = (({1'b0, r_widx} + BW1'(1)) == {1'b0, w_expect});
`ifdef ADDR_RANGE_CHECK_EN
    assign w_bad       = w_tgt[ADDR_LEN-1];
`else
    assign w_bad       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_sel_sr    <= '0;
            r_sel_cnt   <= '0;
            r_is_wr     <= 1'b0;
            r_addr      <= '0;
            r_burst     <= '0;
            r_dsr       <= '0;
            r_dcnt      <= '0;
            r_hold      <= '0;
            r_full      <= 1'b0;
            r_widx      <= '0;
            slave_ready <= 1'b0;
            selected    <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            rx_done     <= 1'b0;
            ovf_err     <= 1'b0;
`ifdef ADDR_RANGE_CHECK_EN
            addr_err    <= 1'b0;
`endif
        end else begin
            mem_wr_en   <= 1'b0;
            rx_done     <= 1'b0;
            slave_ready <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (rx_slave_select) begin
                        r_state   <= S_SEL;
                        r_sel_sr  <= '0;
                        r_sel_cnt <= '0;
                    end
                end
                S_SEL: begin
                    r_sel_sr  <= w_id;
                    r_sel_cnt <= r_sel_cnt + SW'(1);
                    if (r_sel_cnt == SW'(SLAVE_LEN - 1)) begin
                        if (w_id == SLAVE_LEN'(SLAVE_ID)) begin
                            selected <= 1'b1;
                            ovf_err  <= 1'b0;
`ifdef ADDR_RANGE_CHECK_EN
                            addr_err <= 1'b0;
`endif
                            r_tmo    <= '0;
                            r_state  <= S_WAIT;
                        end else begin
                            r_state  <= S_IDLE;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_req_one) begin
                        r_state <= S_XFER;
                        r_is_wr <= write_en;
                        r_cnt   <= CW'(1);
                        r_tmo   <= '0;
                        r_addr  <= '0;
                        r_burst <= '0;
                        r_dsr   <= '0;
                        r_dcnt  <= '0;
                        r_full  <= 1'b0;
                        r_widx  <= '0;
                    end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                        r_state  <= S_IDLE;
                        selected <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_XFER: begin
                    if (w_abort) begin
                        r_state  <= S_IDLE;
                        selected <= 1'b0;
                    end else begin
                        if (!w_hdr_done) begin
                            r_cnt <= r_cnt + CW'(1);
                            if (r_cnt <= C_AEND)
                                r_addr <= {rx_address, r_addr[ADDR_LEN-1:1]};
                            if (r_cnt >= C_TWO && r_cnt <= C_BEND)
                                r_burst <= {rx_burst_number, r_burst[BURST_LEN-1:1]};
                        end
                        if (!r_is_wr) begin
                            if (w_hdr_done) begin
                                if (w_bad) begin
`ifdef ADDR_RANGE_CHECK_EN
                                    addr_err <= 1'b1;
`endif
                                    selected <= 1'b0;
                                    r_state  <= S_IDLE;
                                end else begin
                                    rd_addr     <= r_addr;
                                    rd_req      <= 1'b1;
                                    slave_ready <= 1'b0;
                                    r_state     <= S_RDREQ;
                                end
                            end
                        end else begin
                            if (master_valid) begin
                                r_dsr  <= w_word[DATA_LEN-1:1];
                                r_dcnt <= w_word_done ? '0 : r_dcnt + DW'(1);
                            end
                            if (w_word_done && !w_load)
                                ovf_err <= 1'b1;
                            if (w_load)
                                r_hold <= w_word;
                            if (w_hdr_done) begin
                                if (master_valid) begin
                                    r_tmo <= '0;
                                end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                                    selected <= 1'b0;
                                    r_state  <= S_IDLE;
                                end else begin
                                    r_tmo <= r_tmo + TW'(1);
                                end
                            end
                            if (w_commit) begin
                                r_full <= 1'b0;
                                r_widx <= r_widx + BURST_LEN'(1);
                                if (w_bad) begin
`ifdef ADDR_RANGE_CHECK_EN
                                    addr_err <= 1'b1;
`endif
                                end else begin
                                    mem_wr_en <= 1'b1;
                                    mem_addr  <= w_tgt;
                                    mem_wdata <= r_hold;
                                end
                                if (w_last)
                                    r_state <= S_DONE;
                            end
                            if (w_load)
                                r_full <= 1'b1;
                        end
                    end
                end
                S_RDREQ: begin
                    if (w_abort || rd_ack) begin
                        rd_req   <= 1'b0;
                        selected <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        slave_ready <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (!w_abort)
                        rx_done <= 1'b1;
                    selected <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/slave_in.md
Name: slave_in

Overview:
- Slave-side serial receiver for the system bus; the counterpart of the master transmit path.
- Sequence it handles:
  - Detects the slave-select header and matches it against its own ID.
  - Deserialises address, burst count and write data, all LSB-first.
  - Issues parallel word writes to local slave memory, or raises a read request to the slave's read-return path.
- One instance per slave.

Parameters:
SLAVE_LEN, 2, width of slave-select field
SLAVE_ID, 0, this slave's address on the select line
ADDR_LEN, 12, address bits
DATA_LEN, 8, data bits per word
BURST_LEN, 12, burst-count bits
TIMEOUT, 16, max idle cycles between header and first data bit

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_slave_select  in  1  serial select line (start bit then ID)
rx_address  in  1  serial address
rx_burst_number  in  1  serial burst count
rx_data  in  1  serial write data
master_valid  in  1  rx_data bit valid this cycle
write_en  in  1  master write request
read_en  in  1  master read request
rd_ack  in  1  read path accepted rd_req
slave_ready  out  1  slave can accept transfer
selected  out  1  this slave owns current transaction
mem_wr_en  out  1  one-cycle memory write strobe
mem_addr  out  ADDR_LEN  write address
mem_wdata  out  DATA_LEN  write data
rd_req  out  1  read request, held until rd_ack
rd_addr  out  ADDR_LEN  read address
rx_done  out  1  one-cycle pulse, write transaction complete
ovf_err  out  1  sticky data-overrun flag, cleared on next select

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, counters and shift registers 0.
- slave_ready is 1 in every state except READ_REQ, from the first clock after reset release.
- IDLE:
  - rx_slave_select=1 -> SEL_SHIFT.
  - Then sample SLAVE_LEN bits, one per cycle, LSB-first.
- SEL_SHIFT end:
  - ID==SLAVE_ID -> selected<=1, clear ovf_err, go to WAIT_EN.
  - Otherwise -> IDLE.
- WAIT_EN:
  - Cycle E is the first cycle with write_en^read_en=1.
  - Address bit k is sampled at cycle E+1+k, for k=0..ADDR_LEN-1.
  - Burst line: cycle E+1 is a dummy; burst bit k is sampled at cycle E+2+k.
  - Header completes at E+1+max(ADDR_LEN, BURST_LEN+1).
  - write_en and read_en both 1 -> treated as no request; stay in WAIT_EN.
  - No request within TIMEOUT cycles -> IDLE, selected<=0.
- Read:
  - At header completion: rd_addr<=address, rd_req<=1, go to READ_REQ.
  - On rd_ack: rd_req<=0 -> IDLE.
- Write, data capture:
  - Data capture runs in parallel with header capture, from cycle E+1.
  - Every cycle with master_valid=1 shifts one rx_data bit LSB-first.
  - Every DATA_LEN bits form a word, which is placed in a one-word holding register.
- Write, commit:
  - Commit happens when the holding register is full and the header is complete.
  - mem_wr_en=1 for one cycle; mem_addr = base address + word index (wraps mod 2^ADDR_LEN); mem_wdata = word.
  - Word index starts at 0.
- Write, overrun:
  - A word completing while the holding register is still full sets ovf_err=1.
  - The new word is dropped.
- Write, completion:
  - Words expected = 1 if burst==0, else burst.
  - Cycle after the last commit: rx_done=1 for one cycle, selected<=0 -> IDLE.
- Write, stall: no master_valid for TIMEOUT consecutive cycles after the header -> IDLE, partial word discarded, no rx_done.
- Abort: write_en and read_en both 0 in any non-IDLE state after E -> IDLE next cycle, no memory write.
- Reset mid-transaction aborts immediately; no partial write is emitted.

Optional Feature:
- ADDR_RANGE_CHECK_EN
  - Defined: adds output addr_err (1 bit, reset 0). A commit whose target address is 2^(ADDR_LEN-1) or above is suppressed (mem_wr_en stays 0) and sets addr_err until the next select. A read to such an address raises addr_err instead of rd_req and returns to IDLE. rx_done still pulses at the end of the burst.
  - Undefined: port is absent, and every address is accepted.

Test Plan:
- Select 1,0,1 (ID=2) with SLAVE_ID=2, write_en, address 0x0A5, burst 0, data 0x3C -> one mem_wr_en with mem_addr=0x0A5, mem_wdata=0x3C; rx_done one cycle later; selected=0.
- Select ID=1 with SLAVE_ID=2 -> selected stays 0, no mem_wr_en, slave_ready=1 throughout.
- Burst 3, address 0xFFF, data 0x11/0x22/0x33 -> writes (0xFFF,0x11), (0x000,0x22), (0x001,0x33); single rx_done.
- read_en, address 0x123 -> rd_req=1 with rd_addr=0x123 and slave_ready=0 until rd_ack; next cycle IDLE, slave_ready=1.
- Write with master_valid held low 16 cycles after header -> return to IDLE, no write, no rx_done; reset pulsed low mid-data -> all outputs 0 immediately.
- Burst 2 with DATA_LEN=4, valid from E+1 and second word ending before header completes -> ovf_err=1, only first word written.
